i2s_tx: RTL



---
 rtl/i2s_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter with a one-pair holding register
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data_left,
  input  logic [DATA_WIDTH-1:0] s_data_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * DATA_WIDTH;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;

  logic                  fall_tick;
  logic                  load;
  logic                  accept;
  logic [BIT_W-1:0]      bit_nxt;
  logic [FRAME_BITS-1:0] frame_w;

  // Next-state: BCLK divider, slot counter, serializer and holding register
  always_comb begin
    fall_tick    = (div_q == DIV_LAST);
    bit_nxt      = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    load         = fall_tick && (bit_nxt == BIT_LOAD);
    accept       = s_valid && !hold_full_q;
    frame_w      = {hold_left_q, hold_right_q};

    div_d        = fall_tick ? '0 : div_q + 1'b1;
    bclk_d       = bclk_q;
    bit_d        = bit_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shift_d      = shift_q;
    underrun_d   = 1'b0;
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;

    if (div_q == DIV_RISE) begin
      bclk_d = 1'b1;
    end

    if (fall_tick) begin
      bclk_d  = 1'b0;
      bit_d   = bit_nxt;
      lrclk_d = (bit_nxt >= BIT_HALF);
      if (load) begin
        if (hold_full_q) begin
          // The frame MSB goes straight to SDATA; the rest waits in the shifter
          sdata_d      = frame_w[FRAME_BITS-1];
          shift_d      = {frame_w[FRAME_BITS-2:0], 1'b0};
          hold_full_d  = 1'b0;
          hold_left_d  = '0;
          hold_right_d = '0;
        end else begin
          sdata_d    = 1'b0;
          shift_d    = '0;
          underrun_d = 1'b1;
        end
      end else begin
        sdata_d = shift_q[FRAME_BITS-1];
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    // No bypass: an accept on an empty load edge lands for the next frame
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = s_data_left;
      hold_right_d = s_data_right;
    end
  end

  // State registers with asynchronous reset to the idle-frame position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      bit_q        <= BIT_LAST;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b1;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      shift_q      <= '0;
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
    end else begin
      div_q        <= div_d;
      bit_q        <= bit_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      underrun_q   <= underrun_d;
      shift_q      <= shift_d;
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
    end
  end

  assign s_ready   = !hold_full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule
